// File: rtl/udlx_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Operation codes match op_in as produced by the execute-stage decode.
package udlx_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_CALC  = 2'd1;
  localparam logic [1:0] MD_FIX   = 2'd2;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide for the execute stage.
// Works on magnitudes; signs are restored in the FIX cycle.
module ex_muldiv_unit
  import udlx_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in,
  input  logic                  start_in,
  input  logic [1:0]            op_in,
  input  logic [DATA_WIDTH-1:0] operand_a_in,
  input  logic [DATA_WIDTH-1:0] operand_b_in,
  output logic                  busy_out,
  output logic                  stall_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] result_lo_out,
  output logic [DATA_WIDTH-1:0] result_hi_out,
  output logic                  div_by_zero_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction

  function automatic logic [2*W-1:0] neg_dw(input logic [2*W-1:0] x);
    return ~x + (2*W)'(1);
  endfunction

  logic [1:0]     state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic           is_div_r, neg_res_r, neg_rem_r, dz_r;
  logic [2*W-1:0] acc_r;
  logic [W:0]     rem_r;
  logic [W-1:0]   mcand_r;
  logic           busy_r, done_r, dz_out_r;
  logic [W-1:0]   lo_r, hi_r;

  logic           is_signed_s, is_div_s, b_zero_s, start_ok_s;
  logic [W-1:0]   abs_a_s, abs_b_s;
  logic [W:0]     add_s;
  logic [W:0]     rem_sh_s;
  logic [W+1:0]   diff_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   fix_lo_s, fix_hi_s;

  // Operand decode and per-step arithmetic for both datapaths
  always_comb begin
    is_signed_s = (op_in == MD_MULT) || (op_in == MD_DIV);
    is_div_s    = op_in[1];
    b_zero_s    = (operand_b_in == '0);
    start_ok_s  = start_in && (state_r == MD_IDLE) && !flush_in;
    abs_a_s     = (is_signed_s && operand_a_in[W-1]) ? neg_w(operand_a_in) : operand_a_in;
    abs_b_s     = (is_signed_s && operand_b_in[W-1]) ? neg_w(operand_b_in) : operand_b_in;
    add_s       = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    rem_sh_s    = {rem_r[W-1:0], acc_r[W-1]};
    diff_s      = {1'b0, rem_sh_s} - {2'b00, mcand_r};
  end

  // Sign restoration and result selection for the FIX cycle
  always_comb begin
    prod_s = neg_res_r ? neg_dw(acc_r) : acc_r;
    if (dz_r) begin
      fix_lo_s = '1;
      fix_hi_s = neg_rem_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
    end else if (is_div_r) begin
      fix_lo_s = neg_res_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
      fix_hi_s = neg_rem_r ? neg_w(rem_r[W-1:0]) : rem_r[W-1:0];
    end else begin
      fix_lo_s = prod_s[W-1:0];
      fix_hi_s = prod_s[2*W-1:W];
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt_s = MD_IDLE;
    case (state_r)
      MD_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = (is_div_s && b_zero_s) ? MD_FIX : MD_CALC;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (flush_in) begin
          state_nxt_s = MD_IDLE;
        end else if (cnt_r == '0) begin
          state_nxt_s = MD_FIX;
        end else begin
          state_nxt_s = MD_CALC;
        end
      end
      MD_FIX:  state_nxt_s = MD_IDLE;
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      cnt_r     <= '0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      acc_r     <= '0;
      rem_r     <= '0;
      mcand_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_out_r  <= 1'b0;
      lo_r      <= '0;
      hi_r      <= '0;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s != MD_IDLE);
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (start_ok_s) begin
            is_div_r  <= is_div_s;
            neg_res_r <= is_signed_s && (operand_a_in[W-1] ^ operand_b_in[W-1]);
            neg_rem_r <= (op_in == MD_DIV) && operand_a_in[W-1];
            dz_r      <= is_div_s && b_zero_s;
            cnt_r     <= CW'(W - 1);
            mcand_r   <= is_div_s ? abs_b_s : abs_a_s;
            acc_r     <= {{W{1'b0}}, (is_div_s ? abs_a_s : abs_b_s)};
            rem_r     <= '0;
          end
        end
        MD_CALC: begin
          if (!flush_in) begin
            cnt_r <= cnt_r - CW'(1);
            if (is_div_r) begin
              // Restoring step: keep the subtraction only when it does not borrow
              rem_r <= diff_s[W+1] ? rem_sh_s : diff_s[W:0];
              acc_r <= {acc_r[2*W-1:W], acc_r[W-2:0], ~diff_s[W+1]};
            end else begin
              acc_r <= {add_s, acc_r[W-1:1]};
            end
          end
        end
        MD_FIX: begin
          if (!flush_in) begin
            lo_r     <= fix_lo_s;
            hi_r     <= fix_hi_s;
            done_r   <= 1'b1;
            dz_out_r <= dz_r;
          end
        end
        default: begin
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy_out        = busy_r;
  assign stall_out       = busy_r | start_ok_s;
  assign done_out        = done_r;
  assign result_lo_out   = lo_r;
  assign result_hi_out   = hi_r;
  assign div_by_zero_out = dz_out_r;

endmodule
